// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM frame arbiter: FSM encoding and frame geometry defaults.
package sdram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT
    } arb_state_t;

    localparam int unsigned DEF_BURST_LEN   = 128;
    localparam logic [23:0] DEF_FRAME_LEN   = 24'd480000;
    localparam logic [23:0] DEF_FRAME_BASE0 = 24'h000000;
    localparam logic [23:0] DEF_FRAME_BASE1 = 24'h800000;

endpackage

// File: rtl/frame_addr_gen.sv
// Per-direction frame address generator: burst offset counter, frame wrap detect and bank select.
module frame_addr_gen
    import sdram_arb_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH     = 24,
    parameter int unsigned           BURST_LEN      = DEF_BURST_LEN,
    parameter logic [ADDR_WIDTH-1:0] FRAME_LEN      = ADDR_WIDTH'(DEF_FRAME_LEN),
    parameter logic [ADDR_WIDTH-1:0] FRAME_BASE0    = ADDR_WIDTH'(DEF_FRAME_BASE0),
    parameter logic [ADDR_WIDTH-1:0] FRAME_BASE1    = ADDR_WIDTH'(DEF_FRAME_BASE1),
    parameter logic                  RESET_BANK     = 1'b0,
    parameter logic                  TOGGLE_ON_WRAP = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  advance,
    input  logic                  restart,
    input  logic                  load_bank,
    input  logic                  new_bank,
    output logic                  bank,
    output logic                  wrap,
    output logic [ADDR_WIDTH-1:0] addr
);

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(BURST_LEN);

    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] offset_inc;
    logic [ADDR_WIDTH-1:0] offset_nx;
    logic                  bank_nx;

    assign offset_inc = offset + STEP;
    assign wrap       = advance && !restart && (offset_inc == FRAME_LEN);

    always_comb begin
        offset_nx = offset;
        bank_nx   = bank;
        if (restart) begin
            offset_nx = '0;
        end else if (advance) begin
            offset_nx = wrap ? '0 : offset_inc;
            if (wrap && TOGGLE_ON_WRAP)
                bank_nx = ~bank;
        end
        if (load_bank)
            bank_nx = new_bank;
    end

    // Address is registered from the next-state values so it is already valid when req rises.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            offset <= '0;
            bank   <= RESET_BANK;
            addr   <= RESET_BANK ? FRAME_BASE1 : FRAME_BASE0;
        end else begin
            offset <= offset_nx;
            bank   <= bank_nx;
            addr   <= (bank_nx ? FRAME_BASE1 : FRAME_BASE0) + offset_nx;
        end
    end

endmodule

// File: rtl/sdram_frame_arbiter.sv
// Read/write burst arbiter over a double-buffered SDRAM frame store.
// Optional frame counters are enabled with `define FRAME_ARB_STATS_EN.
module sdram_frame_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned               APP_ADDR_WIDTH  = 24,
    parameter int unsigned               APP_BURST_WIDTH = 9,
    parameter int unsigned               BURST_LEN       = DEF_BURST_LEN,
    parameter logic [APP_ADDR_WIDTH-1:0] FRAME_LEN       = APP_ADDR_WIDTH'(DEF_FRAME_LEN),
    parameter logic [APP_ADDR_WIDTH-1:0] FRAME_BASE0     = APP_ADDR_WIDTH'(DEF_FRAME_BASE0),
    parameter logic [APP_ADDR_WIDTH-1:0] FRAME_BASE1     = APP_ADDR_WIDTH'(DEF_FRAME_BASE1),
    parameter int unsigned               FIFO_LVL_WIDTH  = 10,
    parameter int unsigned               RD_FIFO_DEPTH   = 512
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_frame_start,
    input  logic [FIFO_LVL_WIDTH-1:0]  wr_fifo_level,
    input  logic                       rd_frame_start,
    input  logic [FIFO_LVL_WIDTH-1:0]  rd_fifo_level,
    output logic                       wr_burst_req,
    output logic [APP_BURST_WIDTH-1:0] wr_burst_len,
    output logic [APP_ADDR_WIDTH-1:0]  wr_burst_addr,
    input  logic                       wr_burst_data_req,
    input  logic                       wr_burst_finish,
    output logic                       rd_burst_req,
    output logic [APP_BURST_WIDTH-1:0] rd_burst_len,
    output logic [APP_ADDR_WIDTH-1:0]  rd_burst_addr,
    input  logic                       rd_burst_data_valid,
    input  logic                       rd_burst_finish
`ifdef FRAME_ARB_STATS_EN
    ,
    output logic [15:0]                wr_frame_cnt,
    output logic [15:0]                rd_frame_cnt
`endif
);

    localparam int unsigned           LW           = FIFO_LVL_WIDTH + 1;
    localparam logic [LW-1:0]         BURST_LVL    = LW'(BURST_LEN);
    localparam logic [LW-1:0]         RD_DEPTH_LVL = LW'(RD_FIFO_DEPTH);

    arb_state_t state;
    logic       rd_start_pend;
    logic       wr_start_pend;
    logic       last_done;
    logic       rd_ok;
    logic       wr_ok;
    logic       rd_apply;
    logic       wr_apply;
    logic       rd_adv;
    logic       wr_adv;
    logic       wr_bank;
    logic       wr_wrap;
    logic       rd_bank;
    logic       rd_wrap;
    logic       rd_gen_unused;

    assign rd_ok    = ({1'b0, rd_fifo_level} + BURST_LVL) <= RD_DEPTH_LVL;
    assign wr_ok    = {1'b0, wr_fifo_level} >= BURST_LVL;
    assign rd_apply = (state == IDLE) && rd_start_pend;
    assign wr_apply = (state == IDLE) && wr_start_pend;
    assign rd_adv   = (state == RD_WAIT) && rd_burst_finish;
    assign wr_adv   = (state == WR_WAIT) && wr_burst_finish;

    assign wr_burst_len  = APP_BURST_WIDTH'(BURST_LEN);
    assign rd_burst_len  = APP_BURST_WIDTH'(BURST_LEN);
    assign rd_gen_unused = rd_bank ^ rd_wrap;

    frame_addr_gen #(
        .ADDR_WIDTH     (APP_ADDR_WIDTH),
        .BURST_LEN      (BURST_LEN),
        .FRAME_LEN      (FRAME_LEN),
        .FRAME_BASE0    (FRAME_BASE0),
        .FRAME_BASE1    (FRAME_BASE1),
        .RESET_BANK     (1'b0),
        .TOGGLE_ON_WRAP (1'b1)
    ) u_wr_addr (
        .clk       (clk),
        .rst_n     (rst_n),
        .advance   (wr_adv),
        .restart   (wr_apply),
        .load_bank (1'b0),
        .new_bank  (1'b0),
        .bank      (wr_bank),
        .wrap      (wr_wrap),
        .addr      (wr_burst_addr)
    );

    frame_addr_gen #(
        .ADDR_WIDTH     (APP_ADDR_WIDTH),
        .BURST_LEN      (BURST_LEN),
        .FRAME_LEN      (FRAME_LEN),
        .FRAME_BASE0    (FRAME_BASE0),
        .FRAME_BASE1    (FRAME_BASE1),
        .RESET_BANK     (1'b1),
        .TOGGLE_ON_WRAP (1'b0)
    ) u_rd_addr (
        .clk       (clk),
        .rst_n     (rst_n),
        .advance   (rd_adv),
        .restart   (rd_apply),
        .load_bank (rd_apply),
        .new_bank  (last_done),
        .bank      (rd_bank),
        .wrap      (rd_wrap),
        .addr      (rd_burst_addr)
    );

    // Start pulses landing in the same cycle their pend is consumed are absorbed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            rd_burst_req  <= 1'b0;
            wr_burst_req  <= 1'b0;
            rd_start_pend <= 1'b0;
            wr_start_pend <= 1'b0;
            last_done     <= 1'b1;
`ifdef FRAME_ARB_STATS_EN
            wr_frame_cnt  <= '0;
            rd_frame_cnt  <= '0;
`endif
        end else begin
            rd_start_pend <= rd_apply ? 1'b0 : (rd_start_pend | rd_frame_start);
            wr_start_pend <= wr_apply ? 1'b0 : (wr_start_pend | wr_frame_start);
            if (wr_wrap)
                last_done <= wr_bank;
`ifdef FRAME_ARB_STATS_EN
            if (wr_wrap)
                wr_frame_cnt <= wr_frame_cnt + 16'd1;
            if (rd_apply)
                rd_frame_cnt <= rd_frame_cnt + 16'd1;
`endif
            case (state)
                IDLE: begin
                    if (rd_ok) begin
                        state        <= RD_REQ;
                        rd_burst_req <= 1'b1;
                    end else if (wr_ok) begin
                        state        <= WR_REQ;
                        wr_burst_req <= 1'b1;
                    end
                end
                RD_REQ: begin
                    if (rd_burst_data_valid) begin
                        state        <= RD_WAIT;
                        rd_burst_req <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (rd_burst_finish)
                        state <= IDLE;
                end
                WR_REQ: begin
                    if (wr_burst_data_req) begin
                        state        <= WR_WAIT;
                        wr_burst_req <= 1'b0;
                    end
                end
                WR_WAIT: begin
                    if (wr_burst_finish)
                        state <= IDLE;
                end
                default: begin
                    state        <= IDLE;
                    rd_burst_req <= 1'b0;
                    wr_burst_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Self-checking bench for sdram_frame_arbiter; the bench plays the burst controller.
module tb_sdram_frame_arbiter;

    localparam int BL       = 128;
    localparam int FRAME    = 480000;
    localparam int RD_DEPTH = 512;
    localparam int BASE1    = 32'h800000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_frame_start;
    logic [9:0]  wr_fifo_level;
    logic        rd_frame_start;
    logic [9:0]  rd_fifo_level;
    logic        wr_burst_req;
    logic [8:0]  wr_burst_len;
    logic [23:0] wr_burst_addr;
    logic        wr_burst_data_req;
    logic        wr_burst_finish;
    logic        rd_burst_req;
    logic [8:0]  rd_burst_len;
    logic [23:0] rd_burst_addr;
    logic        rd_burst_data_valid;
    logic        rd_burst_finish;
`ifdef FRAME_ARB_STATS_EN
    logic [15:0] wr_frame_cnt;
    logic [15:0] rd_frame_cnt;
`endif

    sdram_frame_arbiter dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .wr_frame_start      (wr_frame_start),
        .wr_fifo_level       (wr_fifo_level),
        .rd_frame_start      (rd_frame_start),
        .rd_fifo_level       (rd_fifo_level),
        .wr_burst_req        (wr_burst_req),
        .wr_burst_len        (wr_burst_len),
        .wr_burst_addr       (wr_burst_addr),
        .wr_burst_data_req   (wr_burst_data_req),
        .wr_burst_finish     (wr_burst_finish),
        .rd_burst_req        (rd_burst_req),
        .rd_burst_len        (rd_burst_len),
        .rd_burst_addr       (rd_burst_addr),
        .rd_burst_data_valid (rd_burst_data_valid),
        .rd_burst_finish     (rd_burst_finish)
`ifdef FRAME_ARB_STATS_EN
        ,
        .wr_frame_cnt        (wr_frame_cnt),
        .rd_frame_cnt        (rd_frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model of the frame store bookkeeping
    int m_wr_off, m_rd_off, m_wr_frames, m_rd_frames;
    bit m_wr_bank, m_rd_bank, m_last_done, m_rd_pend, m_wr_pend;

    typedef struct {
        int wr_lvl;
        int rd_lvl;
        bit exp_rd;
        bit exp_wr;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int bank_base(input bit b);
        return b ? BASE1 : 0;
    endfunction

    function automatic bit rd_ok_f(input int lvl);
        return (lvl + BL) <= RD_DEPTH;
    endfunction

    function automatic bit wr_ok_f(input int lvl);
        return lvl >= BL;
    endfunction

    task automatic model_reset();
        m_wr_off = 0; m_rd_off = 0; m_wr_frames = 0; m_rd_frames = 0;
        m_wr_bank = 1'b0; m_rd_bank = 1'b1; m_last_done = 1'b1;
        m_rd_pend = 1'b0; m_wr_pend = 1'b0;
    endtask

    // One complete burst handshake; called at a negedge where the DUT sits in IDLE.
    task automatic do_burst(input int acc_dly, input int fin_dly, input bit pulse_rd,
                            input bit pulse_wr, input int pulse_len, input bit stray,
                            output bit saw_rd, output bit saw_wr, output logic [23:0] saw_addr);
        bit exp_rd, exp_wr;
        int exp_addr, waited;
        if (m_rd_pend) begin
            m_rd_off = 0; m_rd_bank = m_last_done; m_rd_frames++; m_rd_pend = 1'b0;
        end
        if (m_wr_pend) begin
            m_wr_off = 0; m_wr_pend = 1'b0;
        end
        exp_rd   = rd_ok_f(int'(rd_fifo_level));
        exp_wr   = !exp_rd && wr_ok_f(int'(wr_fifo_level));
        exp_addr = exp_rd ? bank_base(m_rd_bank) + m_rd_off : bank_base(m_wr_bank) + m_wr_off;
        saw_rd = 1'b0; saw_wr = 1'b0; saw_addr = '0; waited = 0;
        while (waited < 12 && !(rd_burst_req || wr_burst_req)) begin
            @(negedge clk);
            waited++;
        end
        check("req_seen", 32'(rd_burst_req | wr_burst_req), 1);
        if (!(rd_burst_req || wr_burst_req)) return;
        saw_rd   = rd_burst_req;
        saw_wr   = wr_burst_req;
        saw_addr = saw_rd ? rd_burst_addr : wr_burst_addr;
        check("burst_kind", 32'({saw_rd, saw_wr}), 32'({exp_rd, exp_wr}));
        check("idle_gap", waited, 1);
        check("burst_addr", 32'(saw_addr), exp_addr);
        for (int i = 0; i < acc_dly; i++) begin
            if (stray && i == 0) begin
                if (saw_rd) rd_burst_finish = 1'b1; else wr_burst_finish = 1'b1;
            end
            @(negedge clk);
            rd_burst_finish = 1'b0; wr_burst_finish = 1'b0;
            check("req_hold", 32'({rd_burst_req, wr_burst_req}), 32'({saw_rd, saw_wr}));
            check("addr_hold_req", 32'(saw_rd ? rd_burst_addr : wr_burst_addr), 32'(saw_addr));
        end
        if (saw_rd) rd_burst_data_valid = 1'b1; else wr_burst_data_req = 1'b1;
        @(negedge clk);
        rd_burst_data_valid = 1'b0; wr_burst_data_req = 1'b0;
        check("req_drop", 32'({rd_burst_req, wr_burst_req}), 0);
        if (pulse_rd || pulse_wr) begin
            rd_frame_start = pulse_rd; wr_frame_start = pulse_wr;
            repeat (pulse_len) @(negedge clk);
            rd_frame_start = 1'b0; wr_frame_start = 1'b0;
        end
        repeat (fin_dly) @(negedge clk);
        check("addr_hold_wait", 32'(saw_rd ? rd_burst_addr : wr_burst_addr), 32'(saw_addr));
        if (saw_rd) rd_burst_finish = 1'b1; else wr_burst_finish = 1'b1;
        @(negedge clk);
        rd_burst_finish = 1'b0; wr_burst_finish = 1'b0;
        check("post_gap", 32'({rd_burst_req, wr_burst_req}), 0);
        if (exp_rd) begin
            m_rd_off += BL;
            if (m_rd_off == FRAME) m_rd_off = 0;
        end else if (exp_wr) begin
            m_wr_off += BL;
            if (m_wr_off == FRAME) begin
                m_wr_off = 0; m_last_done = m_wr_bank; m_wr_bank = ~m_wr_bank; m_wr_frames++;
            end
        end
        m_rd_pend |= pulse_rd;
        m_wr_pend |= pulse_wr;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit sr, sw, any, last;
        logic [23:0] sa;
        int n, rl, wl;

        vecs[0] = '{128,  512, 1'b0, 1'b1};
        vecs[1] = '{127,  384, 1'b1, 1'b0};
        vecs[2] = '{200,  385, 1'b0, 1'b1};
        vecs[3] = '{127,  385, 1'b0, 1'b0};
        vecs[4] = '{1023, 0,   1'b1, 1'b0};
        vecs[5] = '{129,  513, 1'b0, 1'b1};
        vecs[6] = '{0,    1023, 1'b0, 1'b0};

        rst_n = 1'b0;
        wr_frame_start = 1'b0; rd_frame_start = 1'b0;
        wr_burst_data_req = 1'b0; wr_burst_finish = 1'b0;
        rd_burst_data_valid = 1'b0; rd_burst_finish = 1'b0;
        wr_fifo_level = 10'd128; rd_fifo_level = 10'd512;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_reqs", 32'({rd_burst_req, wr_burst_req}), 0);
        check("rst_wr_addr", 32'(wr_burst_addr), 0);
        check("rst_rd_addr", 32'(rd_burst_addr), BASE1);
        check("wr_len", 32'(wr_burst_len), BL);
        check("rd_len", 32'(rd_burst_len), BL);
`ifdef FRAME_ARB_STATS_EN
        check("rst_cnts", {wr_frame_cnt, rd_frame_cnt}, 0);
`endif
        rst_n = 1'b1;

        do_burst(1, 1, 1'b0, 1'b0, 1, 1'b0, sr, sw, sa);
        check("first_wr", 32'({sw, sa}), 32'({1'b1, 24'h000000}));
        do_burst(0, 2, 1'b0, 1'b0, 1, 1'b0, sr, sw, sa);
        check("second_wr", 32'({sw, sa}), 32'({1'b1, 24'h000080}));
        wr_fifo_level = 10'd200; rd_fifo_level = 10'd100;
        do_burst(2, 1, 1'b0, 1'b0, 1, 1'b0, sr, sw, sa);
        check("rd_priority", 32'({sr, sa}), 32'({1'b1, 24'h800000}));
        rd_fifo_level = 10'd512;
        do_burst(0, 0, 1'b0, 1'b0, 1, 1'b0, sr, sw, sa);
        check("wr_after_rd", 32'({sw, sa}), 32'({1'b1, 24'h000100}));

        foreach (vecs[i]) begin
            wr_fifo_level = 10'(vecs[i].wr_lvl);
            rd_fifo_level = 10'(vecs[i].rd_lvl);
            if (!vecs[i].exp_rd && !vecs[i].exp_wr) begin
                any = 1'b0;
                repeat (6) begin
                    @(negedge clk);
                    any |= rd_burst_req | wr_burst_req;
                end
                check("vec_no_req", 32'(any), 0);
            end else begin
                do_burst(1, 1, 1'b0, 1'b0, 1, 1'b0, sr, sw, sa);
                check("vec_kind", 32'({sr, sw}), 32'({vecs[i].exp_rd, vecs[i].exp_wr}));
            end
        end

        // Fill the rest of frame 0; rd_frame_start lands during the completing burst
        wr_fifo_level = 10'd128; rd_fifo_level = 10'd512;
        n = 0;
        while (m_wr_bank == 1'b0 && n < 4000) begin
            last = (m_wr_off + BL == FRAME);
            do_burst(0, 0, last, 1'b0, 1, 1'b0, sr, sw, sa);
            n++;
        end
        rd_fifo_level = 10'd0;
        do_burst(0, 0, 1'b0, 1'b0, 1, 1'b0, sr, sw, sa);
        check("rd_new_frame", 32'({sr, sa}), 32'({1'b1, 24'h000000}));
        rd_fifo_level = 10'd512;
        do_burst(0, 0, 1'b0, 1'b0, 1, 1'b0, sr, sw, sa);
        check("wr_bank1", 32'({sw, sa}), 32'({1'b1, 24'h800000}));

        for (int k = 0; k < 250; k++) begin
            rl = ($urandom_range(0, 2) == 0) ? 380 + int'($urandom_range(0, 8)) : int'($urandom_range(0, 1023));
            wl = ($urandom_range(0, 2) == 0) ? 124 + int'($urandom_range(0, 8)) : int'($urandom_range(0, 1023));
            if (!rd_ok_f(rl) && !wr_ok_f(wl)) wl = 128 + int'($urandom_range(0, 895));
            rd_fifo_level = 10'(rl);
            wr_fifo_level = 10'(wl);
            do_burst(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                     int'($urandom_range(1, 2)), $urandom_range(0, 1) == 1, sr, sw, sa);
        end

        // Discard a partial write frame at offset 0x1000
        rd_fifo_level = 10'd512; wr_fifo_level = 10'd0;
        repeat (2) @(negedge clk);
        wr_frame_start = 1'b1;
        @(negedge clk);
        wr_frame_start = 1'b0;
        m_wr_pend = 1'b1;
        @(negedge clk);
        wr_fifo_level = 10'd128;
        repeat (32) do_burst(0, 0, 1'b0, 1'b0, 1, 1'b0, sr, sw, sa);
        wr_fifo_level = 10'd0;
        repeat (2) @(negedge clk);
        check("wr_at_1000", 32'(wr_burst_addr), bank_base(m_wr_bank) + 32'h1000);
        wr_frame_start = 1'b1;
        @(negedge clk);
        wr_frame_start = 1'b0;
        m_wr_pend = 1'b1;
        @(negedge clk);
        wr_fifo_level = 10'd128;
        do_burst(0, 0, 1'b0, 1'b0, 1, 1'b0, sr, sw, sa);
        check("wr_restart", 32'({sw, sa}), 32'({1'b1, 24'(bank_base(m_wr_bank))}));

        // Reset while a read request is outstanding
        rd_fifo_level = 10'd0; wr_fifo_level = 10'd0;
        n = 0;
        while (!rd_burst_req && n < 5) begin
            @(negedge clk);
            n++;
        end
        check("pre_rst_rd_req", 32'(rd_burst_req), 1);
`ifdef FRAME_ARB_STATS_EN
        check("wr_frame_cnt", 32'(wr_frame_cnt), m_wr_frames);
        check("rd_frame_cnt", 32'(rd_frame_cnt), m_rd_frames);
`endif
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_reqs", 32'({rd_burst_req, wr_burst_req}), 0);
        check("rst_mid_rd_addr", 32'(rd_burst_addr), BASE1);
        check("rst_mid_wr_addr", 32'(wr_burst_addr), 0);
        rst_n = 1'b1;
        model_reset();
        do_burst(1, 1, 1'b0, 1'b0, 1, 1'b0, sr, sw, sa);
        check("post_rst_rd", 32'({sr, sa}), 32'({1'b1, 24'h800000}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
